// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: lock-state type and default sizes shared by the FIFO write arbiter.
package fifo_arb_pkg;
    localparam int N_DEF = 4;
    localparam int B_DEF = 8;
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_select.sv
// rr_select: one-hot pick of the first request at or above start, wrapping N-1 -> 0.
module rr_select #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    always_comb begin
        grant = '0;
        idx = start;
        // walk offsets downward so the request nearest to start is the one left standing
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                grant = '0;
                grant[(int'(start) + k) % N] = 1'b1;
                idx = IW'((int'(start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter feeding N requesters into one shared FIFO write port.
// Define FIFO_ARB_PKT_LOCK_EN to hold the grant on one requester until its req_last beat.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int B = B_DEF,
    localparam int IW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req_valid,
    input  logic [N*B-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    input  logic           fifo_full,
    output logic           fifo_wr,
    output logic [B-1:0]   fifo_w_data,
    output logic [IW-1:0]  grant_id,
    output logic           locked
);
    logic [IW-1:0] rr_ptr, rr_id, gid;
    logic [N-1:0]  rr_grant, grant;
    logic          xfer, advance;

    rr_select #(.N(N), .IW(IW)) u_rr (
        .req  (req_valid),
        .start(rr_ptr),
        .grant(rr_grant),
        .idx  (rr_id)
    );

`ifdef FIFO_ARB_PKT_LOCK_EN
    lock_state_t   state, state_nxt;
    logic [IW-1:0] lock_id, lock_id_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= UNLOCKED;
            lock_id <= '0;
        end else begin
            state   <= state_nxt;
            lock_id <= lock_id_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lock_id_nxt = lock_id;
        if (xfer && state == UNLOCKED && !req_last[gid]) begin
            state_nxt = LOCKED;
            lock_id_nxt = gid;
        end else if (xfer && state == LOCKED && req_last[gid]) begin
            state_nxt = UNLOCKED;
        end
    end

    // while locked the owner keeps the grant even when it idles
    assign gid     = (state == LOCKED) ? lock_id : rr_id;
    assign grant   = (state == LOCKED) ? N'(1) << lock_id : rr_grant;
    assign advance = xfer && req_last[gid];
    assign locked  = (state == LOCKED);
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign gid     = rr_id;
    assign grant   = rr_grant;
    assign advance = xfer;
    assign locked  = 1'b0;
`endif

    // outputs are gated by reset_n so they read 0 the moment reset asserts
    assign req_ready   = (reset_n && !fifo_full) ? grant : '0;
    assign xfer        = |(req_valid & req_ready);
    assign fifo_wr     = xfer;
    assign fifo_w_data = (reset_n && |grant) ? req_data[gid*B +: B] : '0;
    assign grant_id    = reset_n ? gid : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (advance)
            rr_ptr <= (gid == IW'(N - 1)) ? '0 : gid + 1'b1;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: driver pushes reference-model expectations, a negedge monitor pops and compares.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int B  = 8;
    localparam int IW = 2;
    localparam int DW = N * B;
`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [DW-1:0]  req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   req_ready;
    logic           fifo_wr;
    logic [B-1:0]   fifo_w_data;
    logic [IW-1:0]  grant_id;
    logic           locked;

    typedef struct packed {
        logic          wr;
        logic [N-1:0]  rdy;
        logic [IW-1:0] id;
        logic [B-1:0]  data;
        logic          lk;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int m_ptr = 0;
    int m_owner = 0;
    bit m_lock = 1'b0;
    bit p_wr = 1'b0;
    bit p_last = 1'b0;
    int p_g = 0;
    int waits[N];
    int worst;
    logic [N-1:0] pend = '0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N(N), .B(B)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_w_data(fifo_w_data),
        .grant_id   (grant_id),
        .locked     (locked)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // one cycle: retire last cycle's transfer into the model, drive new inputs, queue the expectation
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l,
                        input logic [DW-1:0] d, input logic f);
        exp_t e;
        int g;
        bit gr;
        @(posedge clk);
        #1;
        if (p_wr) begin
            if (LK && !m_lock && !p_last) begin
                m_lock = 1'b1;
                m_owner = p_g;
            end else if (!LK || p_last) begin
                m_lock = 1'b0;
                m_ptr = (p_g + 1) % N;
            end
        end
        if (!rst) begin
            m_ptr = 0;
            m_lock = 1'b0;
            m_owner = 0;
        end
        reset_n = rst;
        req_valid = v;
        req_last = l;
        req_data = d;
        fifo_full = f;
        gr = 1'b0;
        g = m_ptr;
        if (m_lock) begin
            gr = 1'b1;
            g = m_owner;
        end else begin
            for (int k = 0; k < N; k++)
                if (!gr && v[(m_ptr + k) % N]) begin
                    gr = 1'b1;
                    g = (m_ptr + k) % N;
                end
        end
        e = '0;
        if (rst) begin
            e.id = IW'(g);
            e.lk = m_lock;
            e.rdy = (gr && !f) ? N'(1) << g : '0;
            e.wr = gr && !f && v[g];
            e.data = gr ? d[g*B +: B] : '0;
        end
        p_wr = e.wr;
        p_g = g;
        p_last = l[g];
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        check("wr_while_full", 64'(fifo_wr & fifo_full), 64'd0);
        check("one_ready", 64'($countones(req_ready) <= 1), 64'd1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("fifo_wr", 64'(fifo_wr), 64'(e.wr));
            check("req_ready", 64'(req_ready), 64'(e.rdy));
            check("grant_id", 64'(grant_id), 64'(e.id));
            check("fifo_w_data", 64'(fifo_w_data), 64'(e.data));
            check("locked", 64'(locked), 64'(e.lk));
        end
`ifndef FIFO_ARB_PKT_LOCK_EN
        if (fifo_wr) begin
            worst = 0;
            for (int i = 0; i < N; i++) begin
                if (i == int'(grant_id) || !req_valid[i]) waits[i] = 0;
                else waits[i]++;
                if (waits[i] > worst) worst = waits[i];
            end
            check("starvation_wait", 64'(worst < N), 64'd1);
        end
`endif
    end

    initial begin
        for (int i = 0; i < N; i++) waits[i] = 0;
        step(1'b0, 4'hF, 4'hF, DW'(32'h44332211), 1'b0);
        step(1'b0, 4'hF, 4'hF, DW'(32'h88776655), 1'b0);
        repeat (8) step(1'b1, 4'hF, 4'hF, DW'($urandom), 1'b0);
        step(1'b1, 4'h8, 4'hF, DW'($urandom), 1'b0);
        step(1'b1, 4'h1, 4'hF, DW'($urandom), 1'b0);
        repeat (3) step(1'b1, 4'hF, 4'hF, DW'($urandom), 1'b1);
        step(1'b1, 4'hF, 4'hF, DW'($urandom), 1'b0);
        step(1'b1, 4'h0, 4'h0, DW'($urandom), 1'b0);
`ifdef FIFO_ARB_PKT_LOCK_EN
        step(1'b1, 4'h1, 4'hF, DW'($urandom), 1'b0);
        step(1'b1, 4'h6, 4'h0, DW'($urandom), 1'b0);
        step(1'b1, 4'h6, 4'h0, DW'($urandom), 1'b0);
        step(1'b1, 4'h6, 4'h2, DW'($urandom), 1'b0);
        step(1'b1, 4'h6, 4'hF, DW'($urandom), 1'b0);
        step(1'b1, 4'h4, 4'h0, DW'($urandom), 1'b0);
        step(1'b1, 4'hB, 4'h0, DW'($urandom), 1'b0);
        step(1'b0, 4'hF, 4'h0, DW'($urandom), 1'b0);
        step(1'b1, 4'hF, 4'hF, DW'($urandom), 1'b0);
`endif
        for (int c = 0; c < 10000; c++) begin
            if (p_wr) pend[p_g] = 1'b0;
            pend |= N'($urandom) & N'($urandom);
            step(1'b1, pend, N'($urandom), DW'($urandom), $urandom_range(0, 3) == 0);
        end
        step(1'b1, 4'h0, 4'h0, DW'(0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
